// File: rtl/mc_ctrl_unit_if.sv
// rtl/mc_ctrl_unit_if.sv - IR/memory/datapath control bundle for the multi-cycle MIPS main control FSM
interface mc_ctrl_unit_if;
  logic [5:0] instr_op_i;
  logic       mem_ready_i;
  logic       pc_write_o;
  logic       pc_write_cond_o;
  logic [1:0] pc_src_o;
  logic       i_or_d_o;
  logic       mem_read_o;
  logic       mem_write_o;
  logic       ir_write_o;
  logic       reg_dst_o;
  logic       mem_to_reg_o;
  logic       reg_write_o;
  logic       alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [2:0] ALUOp_o;
  logic [3:0] state_o;
  logic       illegal_o;
  logic       timeout_o;

  // Controller side: consumes opcode/ready, drives the datapath controls.
  modport master (
    input  instr_op_i, mem_ready_i,
    output pc_write_o, pc_write_cond_o, pc_src_o, i_or_d_o, mem_read_o,
           mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o,
           alu_src_a_o, alu_src_b_o, ALUOp_o, state_o, illegal_o, timeout_o
  );

  // Datapath/memory side.
  modport slave (
    output instr_op_i, mem_ready_i,
    input  pc_write_o, pc_write_cond_o, pc_src_o, i_or_d_o, mem_read_o,
           mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o,
           alu_src_a_o, alu_src_b_o, ALUOp_o, state_o, illegal_o, timeout_o
  );
endinterface

// File: rtl/mc_ctrl_unit.sv
// rtl/mc_ctrl_unit.sv - multi-cycle MIPS main control FSM; optional MC_CTRL_PERF_EN adds instruction/cycle counters
module mc_ctrl_unit #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mc_ctrl_unit_if.master bus
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0]    instr_cnt_o,
  output logic [31:0]    cycle_cnt_o
`endif
);

  localparam logic [3:0] WAIT_MAX  = 4'(MEM_WAIT_MAX);
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_J      = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t     state, state_next;
  logic [3:0] wait_cnt, wait_cnt_next;
  logic       wait_hit;

  logic       pc_write_c, pc_write_cond_c, i_or_d_c, mem_read_c, mem_write_c;
  logic       ir_write_c, reg_dst_c, mem_to_reg_c, reg_write_c, alu_src_a_c;
  logic       illegal_c, timeout_c;
  logic [1:0] pc_src_c, alu_src_b_c;
  logic [2:0] alu_op_c;

  // State and memory-wait counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= S_FETCH;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Timeout only fires when ready is absent; ready in the same cycle wins.
  always_comb begin
    wait_hit = (WAIT_MAX != 4'd0) && (wait_cnt == WAIT_MAX) && !bus.mem_ready_i;
  end

  // Next-state and control decode.
  always_comb begin
    state_next      = state;
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    pc_src_c        = 2'b00;
    i_or_d_c        = 1'b0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    ir_write_c      = 1'b0;
    reg_dst_c       = 1'b0;
    mem_to_reg_c    = 1'b0;
    reg_write_c     = 1'b0;
    alu_src_a_c     = 1'b0;
    alu_src_b_c     = 2'b00;
    alu_op_c        = 3'b000;
    illegal_c       = 1'b0;
    timeout_c       = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read_c  = !wait_hit;
        alu_src_b_c = 2'b01;
        if (bus.mem_ready_i) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_next = S_DECODE;
        end else if (wait_hit) begin
          timeout_c  = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_b_c = 2'b11;
        case (bus.instr_op_i)
          OP_RTYPE:       state_next = S_EXEC;
          OP_LW, OP_SW:   state_next = S_MEMADR;
          OP_BEQ:         state_next = S_BRANCH;
          OP_ADDI, OP_ORI: state_next = S_IMMEX;
          OP_J:           state_next = S_JUMP;
          default: begin
            illegal_c  = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_next  = (bus.instr_op_i == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read_c = !wait_hit;
        i_or_d_c   = 1'b1;
        if (bus.mem_ready_i) begin
          state_next = S_MEMWB;
        end else if (wait_hit) begin
          timeout_c  = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_MEMWB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        state_next   = S_FETCH;
      end
      S_MEMWR: begin
        mem_write_c = !wait_hit;
        i_or_d_c    = 1'b1;
        if (bus.mem_ready_i || wait_hit) begin
          timeout_c  = wait_hit;
          state_next = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 3'b010;
        state_next  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = 1'b1;
        state_next  = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c     = 1'b1;
        alu_op_c        = 3'b001;
        pc_write_cond_c = 1'b1;
        pc_src_c        = 2'b01;
        state_next      = S_FETCH;
      end
      S_IMMEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        alu_op_c    = (bus.instr_op_i == OP_ORI) ? 3'b011 : 3'b000;
        state_next  = S_IMMWB;
      end
      S_IMMWB: begin
        reg_write_c = 1'b1;
        state_next  = S_FETCH;
      end
      S_JUMP: begin
        pc_write_c = 1'b1;
        pc_src_c   = 2'b10;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Wait counter restarts on any state change or timeout, counts stalled cycles otherwise.
  always_comb begin
    wait_cnt_next = wait_cnt;
    if ((state_next != state) || timeout_c) begin
      wait_cnt_next = 4'd0;
    end else if (!bus.mem_ready_i && (wait_cnt != 4'hF)) begin
      wait_cnt_next = wait_cnt + 4'd1;
    end
  end

  // Every control output is held low while reset is asserted.
  always_comb begin
    bus.pc_write_o      = rst_i & pc_write_c;
    bus.pc_write_cond_o = rst_i & pc_write_cond_c;
    bus.pc_src_o        = {2{rst_i}} & pc_src_c;
    bus.i_or_d_o        = rst_i & i_or_d_c;
    bus.mem_read_o      = rst_i & mem_read_c;
    bus.mem_write_o     = rst_i & mem_write_c;
    bus.ir_write_o      = rst_i & ir_write_c;
    bus.reg_dst_o       = rst_i & reg_dst_c;
    bus.mem_to_reg_o    = rst_i & mem_to_reg_c;
    bus.reg_write_o     = rst_i & reg_write_c;
    bus.alu_src_a_o     = rst_i & alu_src_a_c;
    bus.alu_src_b_o     = {2{rst_i}} & alu_src_b_c;
    bus.ALUOp_o         = {3{rst_i}} & alu_op_c;
    bus.state_o         = {4{rst_i}} & state;
    bus.illegal_o       = rst_i & illegal_c;
    bus.timeout_o       = rst_i & timeout_c;
  end

`ifdef MC_CTRL_PERF_EN
  logic instr_done;

  // An instruction retires when a final step returns to FETCH; illegal/timeout returns excluded.
  always_comb begin
    instr_done = (state_next == S_FETCH) &&
                 ((state inside {S_MEMWB, S_ALUWB, S_BRANCH, S_IMMWB, S_JUMP}) ||
                  ((state == S_MEMWR) && bus.mem_ready_i));
  end

  // Free-running performance counters, wrapping at 2^32.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      instr_cnt_o <= 32'd0;
      cycle_cnt_o <= 32'd0;
    end else begin
      cycle_cnt_o <= cycle_cnt_o + 32'd1;
      if (instr_done) instr_cnt_o <= instr_cnt_o + 32'd1;
    end
  end
`endif

endmodule
